// File: rtl/fft_magnitude_pipeline.sv
// Streaming magnitude-squared stage: frame capture, LANES-wide 2-stage squaring pipe,
// shift/saturate per bin, and peak tracking in bin order.
module fft_magnitude_pipeline #(
  parameter int unsigned SAMPLE_WIDTH = 32,
  parameter int unsigned BUFFER_SIZE  = 4,
  parameter int unsigned LANES        = 1,
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned IDX_WIDTH    = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] input_real,
  input  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] input_imag,
  input  logic [5:0]                          shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BUFFER_SIZE*OUT_WIDTH-1:0]    output_mags,
  output logic [IDX_WIDTH-1:0]                peak_idx,
  output logic [OUT_WIDTH-1:0]                peak_mag,
  output logic                                saturated
);

  localparam int unsigned NG   = BUFFER_SIZE / LANES;
  localparam int unsigned PW   = 2 * SAMPLE_WIDTH;
  localparam int unsigned SUMW = PW + 1;
  localparam int unsigned CW   = $clog2(NG + 2);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                            state_q;
  logic                              in_ready_q, out_valid_q, sat_q;
  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] re_q, im_q;
  logic [5:0]                        shift_q;
  logic [CW-1:0]                     cnt_q;
  logic                              s1_valid_q;
  logic [CW-1:0]                     s1_grp_q;
  logic [PW-1:0]                     s1_rr_q [LANES];
  logic [PW-1:0]                     s1_ii_q [LANES];
  logic [BUFFER_SIZE*OUT_WIDTH-1:0]  mags_q;
  logic [IDX_WIDTH-1:0]              peak_idx_q;
  logic [OUT_WIDTH-1:0]              peak_mag_q;

  logic [CW-1:0]                     issue_grp_d;
  logic signed [SAMPLE_WIDTH-1:0]    a_d [LANES];
  logic signed [SAMPLE_WIDTH-1:0]    b_d [LANES];
  logic [PW-1:0]                     rr_d [LANES];
  logic [PW-1:0]                     ii_d [LANES];
  logic [SUMW-1:0]                   sum_d [LANES];
  logic [SUMW-1:0]                   shf_d [LANES];
  logic                              lane_sat_d [LANES];
  logic [OUT_WIDTH-1:0]              mag_d [LANES];
  logic [OUT_WIDTH-1:0]              pk_mag_d;
  logic [IDX_WIDTH-1:0]              pk_idx_d;
  logic                              any_sat_d;

  // Stage 1 operands: the group issued this cycle (clamped once issuing is over).
  always_comb begin
    issue_grp_d = (cnt_q < CW'(NG)) ? cnt_q : '0;
    for (int l = 0; l < LANES; l++) begin
      a_d[l]  = re_q[(int'(issue_grp_d) * LANES + l) * SAMPLE_WIDTH +: SAMPLE_WIDTH];
      b_d[l]  = im_q[(int'(issue_grp_d) * LANES + l) * SAMPLE_WIDTH +: SAMPLE_WIDTH];
      rr_d[l] = PW'(a_d[l]) * PW'(a_d[l]);
      ii_d[l] = PW'(b_d[l]) * PW'(b_d[l]);
    end
  end

  // Stage 2: sum, shift, saturate, then fold lanes into the running peak in bin order.
  always_comb begin
    pk_mag_d  = peak_mag_q;
    pk_idx_d  = peak_idx_q;
    any_sat_d = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      sum_d[l]      = SUMW'(s1_rr_q[l]) + SUMW'(s1_ii_q[l]);
      shf_d[l]      = sum_d[l] >> shift_q;
      lane_sat_d[l] = (shf_d[l] >> OUT_WIDTH) != '0;
      mag_d[l]      = lane_sat_d[l] ? '1 : OUT_WIDTH'(shf_d[l]);
      any_sat_d     = any_sat_d | lane_sat_d[l];
      if (mag_d[l] > pk_mag_d) begin
        pk_mag_d = mag_d[l];
        pk_idx_d = IDX_WIDTH'(int'(s1_grp_q) * LANES + l);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_grp_q    <= '0;
      mags_q      <= '0;
      peak_idx_q  <= '0;
      peak_mag_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_rr_q[l] <= '0;
        s1_ii_q[l] <= '0;
      end
    end else begin
      s1_valid_q <= 1'b0;
      if (s1_valid_q) begin
        for (int l = 0; l < LANES; l++)
          mags_q[(int'(s1_grp_q) * LANES + l) * OUT_WIDTH +: OUT_WIDTH] <= mag_d[l];
        peak_mag_q <= pk_mag_d;
        peak_idx_q <= pk_idx_d;
        sat_q      <= sat_q | any_sat_d;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            re_q       <= input_real;
            im_q       <= input_imag;
            shift_q    <= shift;
            cnt_q      <= '0;
            peak_idx_q <= '0;
            peak_mag_q <= '0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt_q < CW'(NG)) begin
            s1_valid_q <= 1'b1;
            s1_grp_q   <= cnt_q;
            for (int l = 0; l < LANES; l++) begin
              s1_rr_q[l] <= rr_d[l];
              s1_ii_q[l] <= ii_d[l];
            end
          end
          // One extra cycle after the last stage-2 write lets the pipe drain.
          if (cnt_q == CW'(NG + 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign output_mags = mags_q;
  assign peak_idx    = peak_idx_q;
  assign peak_mag    = peak_mag_q;
  assign saturated   = sat_q;

endmodule

// File: tb/tb_fft_magnitude_pipeline.sv
// Directed vector table on the default configuration plus random frames on two
// multi-lane configurations (BUFFER_SIZE=8, LANES=4 and LANES=2) against a reference model.
module tb_fft_magnitude_pipeline;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic         iv0, ir0, ov0, or0, sat0;
  logic [127:0] re0, im0, mags0;
  logic [5:0]   sh0;
  logic [1:0]   pidx0;
  logic [31:0]  pmag0;

  // Wide instances share their inputs
  logic         ivw, orw;
  logic [255:0] rew, imw;
  logic [5:0]   shw;
  logic         ir1, ov1, sat1, ir2, ov2, sat2;
  logic [255:0] mags1, mags2;
  logic [2:0]   pidx1, pidx2;
  logic [31:0]  pmag1, pmag2;

  fft_magnitude_pipeline u0 (
    .clk(clk), .reset(rst), .in_valid(iv0), .in_ready(ir0),
    .input_real(re0), .input_imag(im0), .shift(sh0),
    .out_valid(ov0), .out_ready(or0), .output_mags(mags0),
    .peak_idx(pidx0), .peak_mag(pmag0), .saturated(sat0));

  fft_magnitude_pipeline #(.BUFFER_SIZE(8), .LANES(4)) u1 (
    .clk(clk), .reset(rst), .in_valid(ivw), .in_ready(ir1),
    .input_real(rew), .input_imag(imw), .shift(shw),
    .out_valid(ov1), .out_ready(orw), .output_mags(mags1),
    .peak_idx(pidx1), .peak_mag(pmag1), .saturated(sat1));

  fft_magnitude_pipeline #(.BUFFER_SIZE(8), .LANES(2)) u2 (
    .clk(clk), .reset(rst), .in_valid(ivw), .in_ready(ir2),
    .input_real(rew), .input_imag(imw), .shift(shw),
    .out_valid(ov2), .out_ready(orw), .output_mags(mags2),
    .peak_idx(pidx2), .peak_mag(pmag2), .saturated(sat2));

  typedef struct packed {
    logic [3:0][31:0] re;
    logic [3:0][31:0] im;
    logic [5:0]       sh;
    logic [3:0][31:0] mags;
    logic [1:0]       idx;
    logic [31:0]      peak;
    logic             sat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int r0, input int i0, input int r1, input int i1,
                               input int r2, input int i2, input int r3, input int i3,
                               input int sh, input logic [31:0] m0, input logic [31:0] m1,
                               input logic [31:0] m2, input logic [31:0] m3,
                               input int idx, input logic [31:0] pk, input logic s);
    vec_t v;
    v.re   = {32'(r3), 32'(r2), 32'(r1), 32'(r0)};
    v.im   = {32'(i3), 32'(i2), 32'(i1), 32'(i0)};
    v.sh   = 6'(sh);
    v.mags = {m3, m2, m1, m0};
    v.idx  = 2'(idx);
    v.peak = pk;
    v.sat  = s;
    return v;
  endfunction

  function automatic logic [31:0] mag_ref(input logic [31:0] r, input logic [31:0] i,
                                          input int sh, output logic s);
    logic signed [63:0] a, b;
    logic [64:0] sum;
    a   = 64'($signed(r));
    b   = 64'($signed(i));
    sum = 65'(a * a) + 65'(b * b);
    sum = sum >> sh;
    s   = |sum[64:32];
    return s ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Present a frame to u0 and return right after the accepting edge.
  task automatic start0(input vec_t v, input string tag);
    int n;
    re0 = v.re; im0 = v.im; sh0 = v.sh; iv0 = 1'b1;
    n = 0;
    while (!ir0 && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, " in_ready"}, 64'(ir0), 64'(1));
    @(posedge clk); #1;
    iv0 = 1'b0; re0 = {4{32'hDEAD_BEEF}}; im0 = {4{32'h1234_5678}}; sh0 = 6'd17;
  endtask

  // Wait for the result of an accepted frame and check it (no handoff).
  task automatic finish0(input vec_t v, input string tag);
    int lat;
    lat = 0;
    while (!ov0 && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(6));
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s mag%0d", tag, k), 64'(mags0[k*32 +: 32]), 64'(v.mags[k]));
    chk({tag, " peak_idx"}, 64'(pidx0), 64'(v.idx));
    chk({tag, " peak_mag"}, 64'(pmag0), 64'(v.peak));
    chk({tag, " saturated"}, 64'(sat0), 64'(v.sat));
  endtask

  task automatic take0(input string tag);
    or0 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0;
    chk({tag, " out_valid_drop"}, 64'(ov0), 64'(0));
    chk({tag, " in_ready_back"}, 64'(ir0), 64'(1));
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    logic [31:0] exp1 [8];
    logic [31:0] exp2 [8];
    logic [31:0] ep_mag;
    logic [2:0]  ep_idx;
    logic        ep_sat, s;
    bit          seen1, seen2;
    int          sh;

    vecs[0] = mkv(0, 10, 1, 9, 2, 8, 3, 7, 0, 100, 82, 68, 58, 0, 100, 1'b0);
    vecs[1] = mkv(-3, -4, 5, -12, 0, 0, -8, 6, 0, 25, 169, 0, 100, 1, 169, 1'b0);
    vecs[2] = mkv(32'h8000_0000, 32'h8000_0000, 1, 1, 1, 1, 1, 1, 0,
                  32'hFFFF_FFFF, 2, 2, 2, 0, 32'hFFFF_FFFF, 1'b1);
    vecs[3] = mkv(32'h8000_0000, 32'h8000_0000, 1, 1, 1, 1, 1, 1, 32,
                  32'h8000_0000, 0, 0, 0, 0, 32'h8000_0000, 1'b0);
    vecs[4] = mkv(3, 4, 4, 3, 0, 5, 1, 1, 0, 25, 25, 25, 2, 0, 25, 1'b0);
    vecs[5] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    vecs[6] = mkv(0, 10, 1, 9, 2, 8, 3, 7, 1, 50, 41, 34, 29, 0, 50, 1'b0);

    iv0 = 0; or0 = 0; re0 = '0; im0 = '0; sh0 = '0;
    ivw = 0; orw = 0; rew = '0; imw = '0; shw = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset in_ready", 64'(ir0), 64'(1));
    chk("reset out_valid", 64'(ov0), 64'(0));
    chk("reset mags", 64'(mags0[63:0] | mags0[127:64]), 64'(0));
    chk("reset peak", 64'({pidx0, pmag0, sat0}), 64'(0));

    // Directed table on the default instance
    for (int t = 0; t < 7; t++) begin
      start0(vecs[t], $sformatf("vec%0d", t));
      finish0(vecs[t], $sformatf("vec%0d", t));
      take0($sformatf("vec%0d", t));
    end

    // Backpressure: result held, new input ignored while stalled
    start0(vecs[4], "stall");
    finish0(vecs[4], "stall");
    for (int c = 0; c < 10; c++) begin
      iv0 = 1'b1; re0 = {4{32'h0000_7FFF}}; im0 = {4{32'h0000_7FFF}}; sh0 = 6'd0;
      @(posedge clk); #1;
      chk($sformatf("stall%0d out_valid", c), 64'(ov0), 64'(1));
      chk($sformatf("stall%0d in_ready", c), 64'(ir0), 64'(0));
      chk($sformatf("stall%0d mags", c), 64'(mags0[127:64] ^ mags0[63:0]),
          64'({32'd25, 32'd25} ^ {32'd2, 32'd25}));
      chk($sformatf("stall%0d peak", c), 64'({pidx0, pmag0}), 64'({2'd0, 32'd25}));
    end
    iv0 = 1'b0;
    take0("stall");

    // Reset in the middle of COMPUTE
    start0(vecs[0], "midrst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(ov0), 64'(0));
    chk("midrst in_ready", 64'(ir0), 64'(1));
    chk("midrst mags", 64'(mags0[63:0] | mags0[127:64]), 64'(0));
    chk("midrst peak", 64'({pidx0, pmag0, sat0}), 64'(0));
    #2 rst = 1'b0;
    start0(vecs[1], "postrst");
    finish0(vecs[1], "postrst");
    take0("postrst");

    // Random frames on the multi-lane instances
    orw = 1'b1;
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 2))
          0: begin rew[k*32 +: 32] = $urandom; imw[k*32 +: 32] = $urandom; end
          1: begin
            rew[k*32 +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
            imw[k*32 +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
          end
          default: begin
            rew[k*32 +: 32] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            imw[k*32 +: 32] = 32'($urandom_range(0, 3));
          end
        endcase
      end
      sh = (f < 3) ? f * 20 : int'($urandom_range(0, 40));
      shw = 6'(sh);
      ep_mag = '0; ep_idx = '0; ep_sat = 1'b0;
      for (int k = 0; k < 8; k++) begin
        exp1[k] = mag_ref(rew[k*32 +: 32], imw[k*32 +: 32], sh, s);
        exp2[k] = exp1[k];
        ep_sat = ep_sat | s;
        if (exp1[k] > ep_mag) begin ep_mag = exp1[k]; ep_idx = 3'(k); end
      end
      ivw = 1'b1;
      for (int n = 0; n < 50 && !(ir1 && ir2); n++) begin @(posedge clk); #1; end
      chk($sformatf("rnd%0d ready", f), 64'({ir1, ir2}), 64'(2'b11));
      @(posedge clk); #1;
      ivw = 1'b0; rew = ~rew; shw = ~shw;
      seen1 = 0; seen2 = 0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (ov1 && !seen1) begin
          seen1 = 1;
          chk($sformatf("rnd%0d L4 latency", f), 64'(c), 64'(4));
          for (int k = 0; k < 8; k++)
            chk($sformatf("rnd%0d L4 mag%0d", f, k), 64'(mags1[k*32 +: 32]), 64'(exp1[k]));
          chk($sformatf("rnd%0d L4 peak", f), 64'({pidx1, pmag1, sat1}), 64'({ep_idx, ep_mag, ep_sat}));
        end
        if (ov2 && !seen2) begin
          seen2 = 1;
          chk($sformatf("rnd%0d L2 latency", f), 64'(c), 64'(6));
          for (int k = 0; k < 8; k++)
            chk($sformatf("rnd%0d L2 mag%0d", f, k), 64'(mags2[k*32 +: 32]), 64'(exp2[k]));
          chk($sformatf("rnd%0d L2 peak", f), 64'({pidx2, pmag2, sat2}), 64'({ep_idx, ep_mag, ep_sat}));
        end
      end
      chk($sformatf("rnd%0d results_seen", f), 64'({seen1, seen2}), 64'(2'b11));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
